// File: rtl/scan_cfg_loader.sv
// scan_cfg_loader: serialises host config words onto the tile scan chain.
// Define SCAN_CFG_VERIFY_EN for a CRC-checked recirculating read-back pass.
module scan_cfg_loader #(
  parameter int CHAIN_LENGTH = 12,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  fab_scan_in,
  output logic                  fab_scan_en,
  input  logic                  fab_scan_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CW = $clog2(CHAIN_LENGTH + 1);
  localparam int BW = $clog2(WORD_WIDTH + 1);

`ifdef SCAN_CFG_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE, LOAD, SHIFT, VERIFY, DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, LOAD, SHIFT, DONE
  } state_t;
`endif

  state_t                state;
  logic [CW-1:0]         sent;
  logic [BW-1:0]         left;
  logic [WORD_WIDTH-1:0] word;
  logic                  scan_in_q;

  logic [CW-1:0]         remain;
  logic [BW-1:0]         k;
  logic [CW-1:0]         sent_inc;
  logic [WORD_WIDTH-1:0] word_nxt;
  logic                  last_bit;

  assign remain   = CW'(CHAIN_LENGTH) - sent;
  assign k        = (int'(remain) >= WORD_WIDTH) ?
                    BW'(WORD_WIDTH) : BW'(remain);
  assign sent_inc = sent + CW'(1);
  assign word_nxt = word >> 1;
  assign last_bit = (left == BW'(1));

`ifdef SCAN_CFG_VERIFY_EN
  logic [15:0]   crc_tx;
  logic [15:0]   crc_rx;
  logic [15:0]   crc_rx_nxt;
  logic [CW-1:0] vcnt;
  logic          error_q;

  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic        b
  );
    crc_step = {c[14:0], 1'b0} ^
               ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  assign crc_rx_nxt = crc_step(crc_rx, fab_scan_out);
  // read-back recirculates the chain so its contents survive
  assign fab_scan_in = (state == VERIFY) ?
                       fab_scan_out : scan_in_q;
  assign error = error_q;
`else
  wire unused_scan_out = fab_scan_out;
  assign fab_scan_in = scan_in_q;
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sent        <= '0;
      left        <= '0;
      word        <= '0;
      scan_in_q   <= 1'b0;
      cfg_ready   <= 1'b0;
      fab_scan_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef SCAN_CFG_VERIFY_EN
      crc_tx      <= 16'hFFFF;
      crc_rx      <= 16'hFFFF;
      vcnt        <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            sent      <= '0;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
`ifdef SCAN_CFG_VERIFY_EN
            crc_tx    <= 16'hFFFF;
            crc_rx    <= 16'hFFFF;
            error_q   <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (cfg_valid && cfg_ready) begin
            word        <= cfg_data;
            left        <= k;
            scan_in_q   <= cfg_data[0];
            fab_scan_en <= 1'b1;
            cfg_ready   <= 1'b0;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          sent      <= sent_inc;
          left      <= left - BW'(1);
          word      <= word_nxt;
          scan_in_q <= word_nxt[0];
`ifdef SCAN_CFG_VERIFY_EN
          crc_tx    <= crc_step(crc_tx, scan_in_q);
`endif
          if (last_bit) begin
            scan_in_q <= 1'b0;
            if (sent_inc == CW'(CHAIN_LENGTH)) begin
`ifdef SCAN_CFG_VERIFY_EN
              state       <= VERIFY;
              vcnt        <= '0;
`else
              state       <= DONE;
              fab_scan_en <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
`endif
            end else begin
              state       <= LOAD;
              fab_scan_en <= 1'b0;
              cfg_ready   <= 1'b1;
            end
          end
        end
`ifdef SCAN_CFG_VERIFY_EN
        VERIFY: begin
          crc_rx <= crc_rx_nxt;
          vcnt   <= vcnt + CW'(1);
          if (vcnt == CW'(CHAIN_LENGTH - 1)) begin
            state       <= DONE;
            fab_scan_en <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            error_q     <= (crc_rx_nxt != crc_tx);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_cfg_loader.sv
// tb_scan_cfg_loader: random loads against a behavioural scan chain.
// Covers 12x8 and 5x4 geometries; verify pass when macro is set.
module tb_scan_cfg_loader;

`ifdef SCAN_CFG_VERIFY_EN
  localparam int VMUL = 2;
`else
  localparam int VMUL = 1;
`endif
  localparam int EN_EXP = 12 * VMUL;
  localparam int S_EN_EXP = 5 * VMUL;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [7:0] cfg_data = '0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready, fab_scan_in, fab_scan_en;
  logic       scan_out, busy, done, error;

  logic       s_start = 1'b0;
  logic [3:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_ready, s_si, s_en, s_so;
  logic       s_busy, s_done, s_err;

  scan_cfg_loader #(.CHAIN_LENGTH(12), .WORD_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .fab_scan_in(fab_scan_in),
    .fab_scan_en(fab_scan_en), .fab_scan_out(scan_out),
    .busy(busy), .done(done), .error(error)
  );

  scan_cfg_loader #(.CHAIN_LENGTH(5), .WORD_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .start(s_start),
    .cfg_data(s_data), .cfg_valid(s_valid),
    .cfg_ready(s_ready), .fab_scan_in(s_si),
    .fab_scan_en(s_en), .fab_scan_out(s_so),
    .busy(s_busy), .done(s_done), .error(s_err)
  );

  // behavioural tile chains: first bit sent ends at the far end
  logic [11:0] ch = '0;
  logic [4:0]  ch5 = '0;
  int en_cnt = 0, acc_cnt = 0;
  int s_en_cnt = 0, s_acc = 0;
  int flip_at = -1;
  logic stream [64];

  assign scan_out = ch[11] ^ (en_cnt == flip_at);
  assign s_so = ch5[4];

  always @(posedge clk) begin
    if (fab_scan_en) begin
      ch <= {ch[10:0], fab_scan_in};
      stream[en_cnt % 64] <= fab_scan_in;
      en_cnt <= en_cnt + 1;
    end
    if (cfg_valid && cfg_ready) acc_cnt <= acc_cnt + 1;
    if (s_en) begin
      ch5 <= {ch5[3:0], s_si};
      s_en_cnt <= s_en_cnt + 1;
    end
    if (s_valid && s_ready) s_acc <= s_acc + 1;
  end

  int checks = 0, errors = 0;
  logic [7:0] wq[$];

  function automatic logic [11:0] exp_main();
    logic [11:0] e;
    logic [7:0] w;
    for (int n = 0; n < 12; n++) begin
      w = wq[n / 8];
      e[11 - n] = w[n % 8];
    end
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; cfg_valid = 1'b0;
    s_start = 1'b0; s_valid = 1'b0; flip_at = -1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_main(input int gmin, input int gmax,
                          input int rst_at, input int start_at,
                          output bit aborted);
    int idx, stall, t, b0, e0;
    bit sp;
    idx = 0; t = 0; sp = 1'b0; aborted = 1'b0; stall = 0;
    b0 = en_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && t < 600) begin
      if (rst_at >= 0 && en_cnt - b0 == rst_at) begin
        rst = 1'b1; cfg_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({cfg_ready, fab_scan_in, fab_scan_en,
             busy, done, error} !== 6'b0) begin
          errors++;
          $display("FAIL mid_reset_outputs: got %b want 000000",
                   {cfg_ready, fab_scan_in, fab_scan_en,
                    busy, done, error});
        end
        e0 = en_cnt;
        repeat (5) @(negedge clk);
        checks++;
        if (en_cnt != e0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL mid_reset_idle: shifts %0d busy %b want 0 0",
                   en_cnt - e0, busy);
        end
        aborted = 1'b1;
        return;
      end
      if (start_at >= 0 && !sp && en_cnt - b0 == start_at) begin
        start = 1'b1; sp = 1'b1;
      end else start = 1'b0;
      if (cfg_ready && idx < wq.size()) begin
        if (stall > 0) begin
          cfg_valid = 1'b0; stall--;
          checks++;
          if (fab_scan_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_idle: en=%b busy=%b want en=0 busy=1",
                     fab_scan_en, busy);
          end
        end else begin
          cfg_valid = 1'b1; cfg_data = wq[idx]; idx++;
          stall = $urandom_range(gmax, gmin);
        end
      end else begin
        cfg_valid = 1'b0; cfg_data = 8'($urandom);
      end
      @(negedge clk);
      t++;
    end
    cfg_valid = 1'b0; start = 1'b0;
    checks++;
    if (t >= 600) begin
      errors++;
      $display("FAIL load_timeout: done=%b after %0d cycles want 1",
               done, t);
    end
  endtask

  task automatic check_load(input string nm, input int b0,
                            input int a0);
    checks++;
    if (en_cnt - b0 != EN_EXP) begin
      errors++;
      $display("FAIL %s_en_cycles: got %0d want %0d",
               nm, en_cnt - b0, EN_EXP);
    end
    checks++;
    if (acc_cnt - a0 != 2) begin
      errors++;
      $display("FAIL %s_words: got %0d want 2", nm, acc_cnt - a0);
    end
    checks++;
    if (ch !== exp_main()) begin
      errors++;
      $display("FAIL %s_chain: got %h want %h", nm, ch, exp_main());
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL %s_status: done/busy/err %b%b%b want 100",
               nm, done, busy, error);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({cfg_ready, fab_scan_in, fab_scan_en,
         busy, done, error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 000000",
               {cfg_ready, fab_scan_in, fab_scan_en,
                busy, done, error});
    end
  endtask

  task automatic test_basic();
    int b0, a0;
    bit ab;
    logic [11:0] s_exp, s_got;
    do_reset();
    wq = {8'hA5, 8'h0C};
    b0 = en_cnt; a0 = acc_cnt;
    run_main(0, 0, -1, -1, ab);
    s_exp = 12'hCA5;
    for (int n = 0; n < 12; n++) s_got[n] = stream[(b0 + n) % 64];
    checks++;
    if (s_got !== s_exp) begin
      errors++;
      $display("FAIL basic_stream: got %b want %b (LSB first)",
               s_got, s_exp);
    end
    check_load("basic", b0, a0);
  endtask

  task automatic test_backpressure();
    int b0, a0;
    bit ab;
    do_reset();
    wq = {8'hA5, 8'h0C};
    b0 = en_cnt; a0 = acc_cnt;
    run_main(5, 5, -1, -1, ab);
    check_load("bp", b0, a0);
  endtask

  task automatic test_random();
    int b0, a0;
    bit ab;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      wq = {8'($urandom), 8'($urandom)};
      b0 = en_cnt; a0 = acc_cnt;
      run_main(0, 3, -1, -1, ab);
      check_load("rand", b0, a0);
    end
  endtask

  task automatic test_mid_reset();
    int b0, a0;
    bit ab;
    do_reset();
    wq = {8'($urandom), 8'($urandom)};
    run_main(0, 0, 3, -1, ab);
    checks++;
    if (ab !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_reached: got %b want 1", ab);
    end
    wq = {8'($urandom), 8'($urandom)};
    b0 = en_cnt; a0 = acc_cnt;
    run_main(0, 2, -1, -1, ab);
    check_load("reload", b0, a0);
  endtask

  task automatic test_ignored_start();
    int b0, a0;
    bit ab;
    do_reset();
    wq = {8'($urandom), 8'($urandom)};
    b0 = en_cnt; a0 = acc_cnt;
    run_main(0, 1, -1, 5, ab);
    check_load("busy_start", b0, a0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL done_restart: done=%b ready=%b want 0 1",
               done, cfg_ready);
    end
  endtask

  task automatic test_partial();
    logic [3:0] w0, w1;
    logic [4:0] e;
    int b0, a0, t;
    int idx;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      w0 = (it == 0) ? 4'hF : 4'($urandom);
      w1 = (it == 0) ? 4'h1 : 4'($urandom);
      for (int n = 0; n < 4; n++) e[4 - n] = w0[n];
      e[0] = w1[0];
      b0 = s_en_cnt; a0 = s_acc; t = 0; idx = 0;
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      while (!s_done && t < 200) begin
        if (s_ready && idx < 2) begin
          s_valid = 1'b1; s_data = (idx == 0) ? w0 : w1; idx++;
        end else s_valid = 1'b0;
        @(negedge clk);
        t++;
      end
      s_valid = 1'b0;
      checks++;
      if (t >= 200) begin
        errors++;
        $display("FAIL part_timeout: done=%b want 1", s_done);
      end
      checks++;
      if (s_en_cnt - b0 != S_EN_EXP || s_acc - a0 != 2) begin
        errors++;
        $display("FAIL part_counts: en %0d words %0d want %0d 2",
                 s_en_cnt - b0, s_acc - a0, S_EN_EXP);
      end
      checks++;
      if (ch5 !== e || s_err !== 1'b0) begin
        errors++;
        $display("FAIL part_chain: got %b err %b want %b err 0",
                 ch5, s_err, e);
      end
    end
  endtask

`ifdef SCAN_CFG_VERIFY_EN
  task automatic test_verify();
    int b0, a0;
    bit ab;
    do_reset();
    wq = {8'($urandom), 8'($urandom)};
    b0 = en_cnt; a0 = acc_cnt;
    run_main(0, 2, -1, -1, ab);
    check_load("verify_clean", b0, a0);
    do_reset();
    wq = {8'($urandom), 8'($urandom)};
    flip_at = en_cnt + 12 + 3;
    run_main(0, 0, -1, -1, ab);
    flip_at = -1;
    checks++;
    if (done !== 1'b1 || error !== 1'b1) begin
      errors++;
      $display("FAIL verify_flip: done=%b err=%b want 1 1",
               done, error);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (error !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL verify_sticky: err=%b done=%b want 1 1",
               error, done);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (error !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL verify_clear: err=%b ready=%b want 0 1",
               error, cfg_ready);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_mid_reset();
    test_ignored_start();
    test_partial();
`ifdef SCAN_CFG_VERIFY_EN
    test_verify();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_cfg_loader.md
Name: scan_cfg_loader

Overview:
- Configuration loader that drives the serial config chain of the switch-box and CLB tiles (the `scan_in`/`scan_en` → `shift_reg` chain).
- Accepts config words from the host/bitstream side over a valid/ready handshake.
- Serialises exactly CHAIN_LENGTH bits onto the chain, then reports done.
- Sits directly upstream of the first tile's `scan_in`; the chain's final `scan_out` returns to it.

Parameters:
- CHAIN_LENGTH, 12, total config bits in the chain (3 × 4 for one bottom-edge SB); must be ≥1.
- WORD_WIDTH, 8, width of `cfg_data`; must be ≥1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load from IDLE or DONE.
- cfg_data  input  WORD_WIDTH  config word, LSB shifted first.
- cfg_valid  input  1  `cfg_data` valid.
- cfg_ready  output  1  loader accepts a word this cycle.
- fab_scan_in  output  1  drives the chain's `scan_in`.
- fab_scan_en  output  1  drives the chain's `scan_en`; the chain shifts only when high and holds otherwise.
- fab_scan_out  input  1  chain's final `scan_out`, return path.
- busy  output  1  high in LOAD/SHIFT/VERIFY.
- done  output  1  level, high in DONE.
- error  output  1  verify mismatch, sticky until `start`/`rst`.

Behaviour:
- **Reset** (`rst`=1 at an edge): state=IDLE next cycle. All outputs 0: `cfg_ready`, `fab_scan_in`, `fab_scan_en`, `busy`, `done`, `error`. Counters cleared.
- **Reset mid-operation** has the same effect. `fab_scan_en` is low the cycle after and the chain keeps its partial contents; no further bits are shifted.
- **Outputs are registered.** The only exception is `fab_scan_in` in VERIFY (see below).
- **IDLE:** on `start`, go to LOAD. Clear the sent-bit counter (width `$clog2(CHAIN_LENGTH+1)`), `done`, and `error`.
- **DONE:** holds `done`=1. `start` behaves as in IDLE, allowing a reload.
- **`start` while busy** is ignored.
- **LOAD:** `cfg_ready`=1 and `fab_scan_en`=0.
  - When `cfg_valid` && `cfg_ready` at edge t, latch the word, compute k = min(WORD_WIDTH, CHAIN_LENGTH − sent), and go to SHIFT.
  - `cfg_ready` drops at t+1.
- **SHIFT:** in cycles t+1 … t+k, `fab_scan_en`=1 and `fab_scan_in` = word bit i (i = 0 … k−1, LSB first). Sent count increments each cycle.
  - After bit k−1: if sent == CHAIN_LENGTH, go to DONE (or VERIFY when the macro is enabled); otherwise go to LOAD.
  - Bits of the final word above bit k−1 are discarded.
- **Host stalls** (`cfg_valid` low in LOAD) keep `fab_scan_en` low; no spurious shifts.
- **Totals per load:**
  - `fab_scan_en` is high for exactly CHAIN_LENGTH cycles, not counting VERIFY.
  - Words consumed = ceil(CHAIN_LENGTH / WORD_WIDTH).
- **Bit placement:** the first bit sent ends in the chain position farthest from the loader.
- **No timeout.** The loader waits in LOAD indefinitely.

Optional Feature:
- Macro: SCAN_CFG_VERIFY_EN.
- **With the macro:**
  - A CRC-16 (poly 0x1021, init 0xFFFF, bit-serial: fb = crc[15] ^ bit; crc = {crc[14:0],0} ^ (fb ? 0x1021 : 0)) runs over each bit sent in SHIFT.
  - After the last bit, the FSM enters VERIFY for exactly CHAIN_LENGTH cycles. `fab_scan_en`=1 and `fab_scan_in` = `fab_scan_out` (combinational recirculation), so the config is restored intact.
  - A second CRC (same init) runs over the sampled `fab_scan_out`.
  - On exit to DONE, `error` = (crc_sent ≠ crc_returned), and `done`=1 in the same cycle.
- **Without the macro:** no VERIFY state and no CRC logic. `error` is tied to 0; the FSM goes SHIFT → DONE.

Test Plan:
1. **Basic load:** defaults, a behavioural 12-bit chain model, `start`, words 0xA5 then 0x0C presented back-to-back.
   - Serial stream is 1,0,1,0,0,1,0,1,0,0,1,1.
   - `fab_scan_en` is high for 12 load cycles; `done`=1; 2 words accepted; the 0x0C upper nibble is ignored.
2. **Backpressure:** same data, `cfg_valid` low for 5 cycles between the words.
   - `fab_scan_en` is 0 during the gap; the chain contents match scenario 1; `busy` stays high throughout.
3. **Mid-shift reset:** `rst` after 3 bits of word 0.
   - Next cycle all outputs are 0 and the state is IDLE.
   - A subsequent `start` plus a full load gives the correct 12-bit chain contents.
4. **Ignored start:** `start` pulsed mid-SHIFT → no restart and the bit count is unchanged. `start` in DONE → `done` drops next cycle and `cfg_ready`=1.
5. **Partial final word:** CHAIN_LENGTH=5, WORD_WIDTH=4, words 0xF and 0x1.
   - Exactly 5 `fab_scan_en` cycles; the second word contributes only bit 0 (value 1).
6. **Verify** (SCAN_CFG_VERIFY_EN):
   - Clean chain model → `error`=0 and chain contents are unchanged after VERIFY.
   - Model flips one returned bit → `error`=1, which persists in DONE until `start`.
